// File: rtl/oled_arb_pkg.sv
// Shared types and constants for the PmodOLED SPI arbiter.
package oled_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SHIFT,
    ST_RELEASE
  } arb_state_t;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DEF_CLK_DIV = 4;

endpackage

// File: rtl/oled_spi_byte_tx.sv
// CLK_DIV-timed 8-bit SPI mode-3 shifter, MSB first; SCLK idles high.
module oled_spi_byte_tx
  import oled_arb_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [BYTE_W-1:0] data,
  output logic              SCLK,
  output logic              SDIN,
  output logic              done
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0]     cnt_q;
  logic [2:0]        bit_q;
  logic [BYTE_W-2:0] sh_q;
  logic              sclk_q;
  logic              sdin_q;
  logic              busy_q;

  // Asserted in the final cycle of the last high half-period.
  assign done = busy_q && sclk_q && (cnt_q == HALF_LAST) && (bit_q == 3'd7);
  assign SCLK = sclk_q;
  assign SDIN = sdin_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      sclk_q <= 1'b1;
      sdin_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (!busy_q) begin
      if (start) begin
        busy_q <= 1'b1;
        sclk_q <= 1'b0;
        sdin_q <= data[BYTE_W-1];
        sh_q   <= data[BYTE_W-2:0];
        cnt_q  <= '0;
        bit_q  <= '0;
      end
    end else if (cnt_q == HALF_LAST) begin
      cnt_q <= '0;
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else if (bit_q == 3'd7) begin
        busy_q <= 1'b0;
      end else begin
        sclk_q <= 1'b0;
        sdin_q <= sh_q[BYTE_W-2];
        sh_q   <= {sh_q[BYTE_W-3:0], 1'b0};
        bit_q  <= bit_q + 3'd1;
      end
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Round-robin arbiter sharing the PmodOLED SPI port among NUM_REQ byte requesters.
// Optional idle-grant watchdog enabled by defining OLED_ARB_TIMEOUT_EN.
module oled_spi_arbiter
  import oled_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ,
  output logic [NUM_REQ-1:0]        GNT,
  input  logic [NUM_REQ-1:0]        BYTE_VALID,
  input  logic [BYTE_W*NUM_REQ-1:0] BYTE_DATA,
  input  logic [NUM_REQ-1:0]        BYTE_DC,
  output logic [NUM_REQ-1:0]        BYTE_READY,
  output logic                      CS,
  output logic                      SDIN,
  output logic                      SCLK,
  output logic                      DC,
  output logic                      BUSY,
  output logic                      TIMEOUT
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] REL_LAST = CW'(CLK_DIV - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || CLK_DIV < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("oled_spi_arbiter: parameter out of range");
  end

  arb_state_t        state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IW-1:0]     gidx_q, ptr_q, sel_idx, next_ptr;
  logic [NUM_REQ-1:0] sel_onehot;
  logic              sel_found;
  logic [CW-1:0]     rel_cnt_q;
  logic              cs_q, dc_q;
  logic              g_req, g_valid, g_dc;
  logic [BYTE_W-1:0] g_data;
  logic              xfer, release_go, wd_expire, tx_done;
  int unsigned       idx;

  // Round-robin search from the pointer with wrap, plus the granted requester's lane mux.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    idx        = 0;
    g_req      = 1'b0;
    g_valid    = 1'b0;
    g_dc       = 1'b0;
    g_data     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!sel_found && REQ[idx]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(idx);
      end
    end
    sel_onehot[sel_idx] = 1'b1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IW'(i)) begin
        g_req   = REQ[i];
        g_valid = BYTE_VALID[i];
        g_dc    = BYTE_DC[i];
        g_data  = BYTE_DATA[BYTE_W*i +: BYTE_W];
      end
    end
  end

  assign xfer       = (state_q == ST_GRANT) && g_valid;
  assign release_go = (state_q == ST_GRANT) && !xfer && (!g_req || wd_expire);
  assign next_ptr   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

  assign GNT        = gnt_q;
  assign BYTE_READY = (state_q == ST_GRANT) ? gnt_q : '0;
  assign CS         = cs_q;
  assign DC         = dc_q;
  assign BUSY       = (state_q != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (sel_found) state_d = ST_GRANT;
      ST_GRANT: begin
        if (xfer)            state_d = ST_SHIFT;
        else if (release_go) state_d = ST_RELEASE;
      end
      ST_SHIFT:   if (tx_done) state_d = ST_GRANT;
      ST_RELEASE: if (rel_cnt_q == REL_LAST) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // CS drops on the first accepted byte and stays low until the grant is released.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      rel_cnt_q <= '0;
      cs_q      <= 1'b1;
      dc_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_found) begin
            gnt_q  <= sel_onehot;
            gidx_q <= sel_idx;
          end
        end
        ST_GRANT: begin
          if (xfer) begin
            cs_q <= 1'b0;
            dc_q <= g_dc;
          end else if (release_go) begin
            gnt_q     <= '0;
            cs_q      <= 1'b1;
            rel_cnt_q <= '0;
            ptr_q     <= next_ptr;
          end
        end
        ST_RELEASE: rel_cnt_q <= rel_cnt_q + CW'(1);
        default: ;
      endcase
    end
  end

`ifdef OLED_ARB_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q;
  logic          timeout_q;

  assign wd_expire = (state_q == ST_GRANT) && !g_valid && (wd_q == WW'(TIMEOUT_CYCLES - 1));
  assign TIMEOUT   = timeout_q;

  always_ff @(posedge CLK) begin
    if (RST || state_q != ST_GRANT || xfer) wd_q <= '0;
    else                                    wd_q <= wd_q + WW'(1);
    if (RST) timeout_q <= 1'b0;
    else     timeout_q <= wd_expire;
  end
`else
  assign wd_expire = 1'b0;
  assign TIMEOUT   = 1'b0;
`endif

  oled_spi_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_tx (
    .CLK  (CLK),
    .RST  (RST),
    .start(xfer),
    .data (g_data),
    .SCLK (SCLK),
    .SDIN (SDIN),
    .done (tx_done)
  );

endmodule
